// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: FSM state encoding, default
// requester count and the datapath widths taken from the global defines.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

package alu_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEFAULT_NUM_REQ = 2;
    localparam int DATA_W          = `DATA_WIDTH;
    localparam int OP_W            = `ALU_OP_WIDTH;
endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: the search starts one past last_grant
// and wraps; the grant is one-hot, or all-zero when disabled or idle.
module rr_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters: grant,
// latch operands, capture the ALU result, then hold the response for its owner.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*`DATA_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*`DATA_WIDTH-1:0]  req_b,
    input  logic [NUM_REQ*`ALU_OP_WIDTH-1:0] req_op,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [`DATA_WIDTH-1:0]          rsp_data,
    output logic [`DATA_WIDTH-1:0]          alu_a,
    output logic [`DATA_WIDTH-1:0]          alu_b,
    output logic [`ALU_OP_WIDTH-1:0]        alu_op,
    input  logic [`DATA_WIDTH-1:0]          alu_out,
    output logic                            busy
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [DATA_W-1:0]  sel_a, sel_b;
    logic [OP_W-1:0]    sel_op;
    logic               arb_enable;

    // Gating with rst_n keeps req_ready low for the whole time reset is held.
    assign arb_enable = (state_q == IDLE) && rst_n;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .enable     (arb_enable),
        .grant      (grant)
    );

    always_comb begin
        grant_idx = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = ID_W'(i);
                sel_a     = req_a[i*DATA_W +: DATA_W];
                sel_b     = req_b[i*DATA_W +: DATA_W];
                sel_op    = req_op[i*OP_W +: OP_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid    = '0;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    state_d      = EXEC;
                    last_grant_d = grant_idx;
                    id_d         = grant_idx;
                    a_d          = sel_a;
                    b_d          = sel_b;
                    op_d         = sel_op;
                end
            end
            EXEC: begin
                rsp_data_d = alu_out;
                state_d    = RESP;
            end
            RESP: begin
                // Only the owner's rsp_ready can retire the response.
                rsp_valid[id_q] = 1'b1;
                if (rsp_ready[id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign req_ready = grant;
    assign rsp_data  = rsp_data_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios on 2- and 4-requester
// instances plus a randomized run against a transaction-level reference model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module tb_alu_arbiter;
    localparam int DW  = `DATA_WIDTH;
    localparam int OPW = `ALU_OP_WIDTH;

    localparam logic [OPW-1:0] ALU_OP_ADD = 0, ALU_OP_SUB = 1, ALU_OP_AND = 2,
                               ALU_OP_OR  = 3, ALU_OP_XOR = 4, ALU_OP_SLT = 5,
                               ALU_OP_SLL = 6, ALU_OP_SRL = 7, ALU_OP_SRA = 8;

    logic clk, rst_n;
    int   vectors, miscompares;

    logic [1:0]      v2, rdy2, rv2, rr2;
    logic [2*DW-1:0] a2, b2;
    logic [2*OPW-1:0] op2;
    logic [DW-1:0]   rd2, aa2, ab2, aout2;
    logic [OPW-1:0]  aop2;
    logic            busy2;

    logic [3:0]      v4, rdy4, rv4, rr4;
    logic [4*DW-1:0] a4, b4;
    logic [4*OPW-1:0] op4;
    logic [DW-1:0]   rd4, aa4, ab4, aout4;
    logic [OPW-1:0]  aop4;
    logic            busy4;

    // Stand-in for the external shared ALU.
    function automatic logic [DW-1:0] alu_model(input logic [OPW-1:0] op,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        case (op)
            ALU_OP_ADD: return a + b;
            ALU_OP_SUB: return a - b;
            ALU_OP_AND: return a & b;
            ALU_OP_OR:  return a | b;
            ALU_OP_XOR: return a ^ b;
            ALU_OP_SLT: return DW'($signed(a) < $signed(b));
            ALU_OP_SLL: return a << b[4:0];
            ALU_OP_SRL: return a >> b[4:0];
            ALU_OP_SRA: return DW'($signed(a) >>> b[4:0]);
            default:    return '0;
        endcase
    endfunction

    assign aout2 = alu_model(aop2, aa2, ab2);
    assign aout4 = alu_model(aop4, aa4, ab4);

    alu_arbiter dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v2), .req_ready(rdy2), .req_a(a2), .req_b(b2), .req_op(op2),
        .rsp_valid(rv2), .rsp_ready(rr2), .rsp_data(rd2),
        .alu_a(aa2), .alu_b(ab2), .alu_op(aop2), .alu_out(aout2), .busy(busy2)
    );

    alu_arbiter #(.NUM_REQ(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v4), .req_ready(rdy4), .req_a(a4), .req_b(b4), .req_op(op4),
        .rsp_valid(rv4), .rsp_ready(rr4), .rsp_data(rd4),
        .alu_a(aa4), .alu_b(ab4), .alu_op(aop4), .alu_out(aout4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req2(input int i, input logic [OPW-1:0] op,
                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        a2[i*DW +: DW]   = a;
        b2[i*DW +: DW]   = b;
        op2[i*OPW +: OPW] = op;
    endtask

    task automatic do_reset();
        v2 = '0; rr2 = '0; a2 = '0; b2 = '0; op2 = '0;
        v4 = '0; rr4 = '0; a4 = '0; b4 = '0; op4 = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        v2 = 2'b11; v4 = 4'hF; rr2 = '0; rr4 = '0;
        a2 = '0; b2 = '0; op2 = '0; a4 = '0; b4 = '0; op4 = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (rdy2 !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_req_ready got %b expected 00", rdy2); end
        vectors++; if (rv2 !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_rsp_valid got %b expected 00", rv2); end
        vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b expected 0", busy2); end
        vectors++; if ({rd2, aa2, ab2, aop2} !== '0) begin miscompares++; $display("[TB] FAIL reset_data got %h/%h/%h/%h expected 0", rd2, aa2, ab2, aop2); end
        vectors++; if (rdy4 !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_req_ready4 got %b expected 0000", rdy4); end
    endtask

    task automatic test_single();
        do_reset();
        set_req2(0, ALU_OP_ADD, 5, 7);
        v2 = 2'b01; rr2 = 2'b11;
        @(negedge clk);
        vectors++; if (rdy2 !== 2'b01) begin miscompares++; $display("[TB] FAIL single_grant got %b expected 01", rdy2); end
        @(posedge clk); #1; v2 = 2'b00;
        @(negedge clk);
        vectors++; if ({rdy2, rv2, busy2} !== 5'b00001) begin miscompares++; $display("[TB] FAIL single_exec got rdy=%b rv=%b busy=%b expected 00/00/1", rdy2, rv2, busy2); end
        vectors++; if ({aa2, ab2, aop2} !== {DW'(5), DW'(7), ALU_OP_ADD}) begin miscompares++; $display("[TB] FAIL single_operands got %h %h %h expected 5 7 0", aa2, ab2, aop2); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (rv2 !== 2'b01) begin miscompares++; $display("[TB] FAIL single_rsp_valid got %b expected 01", rv2); end
        vectors++; if (rd2 !== DW'(12)) begin miscompares++; $display("[TB] FAIL single_rsp_data got %0d expected 12", rd2); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if ({busy2, rv2} !== 3'b000) begin miscompares++; $display("[TB] FAIL single_idle got busy=%b rv=%b expected 0/00", busy2, rv2); end
    endtask

    task automatic test_contention();
        int exp_id;
        logic [1:0] exp_oh;
        logic [DW-1:0] exp_res;
        do_reset();
        set_req2(0, ALU_OP_SUB, 10, 3);
        set_req2(1, ALU_OP_SLT, '1, 1);
        v2 = 2'b11; rr2 = 2'b11;
        for (int k = 0; k < 3; k++) begin
            exp_id  = k % 2;
            exp_oh  = 2'(1 << exp_id);
            exp_res = (exp_id == 0) ? DW'(7) : DW'(1);
            @(negedge clk);
            vectors++; if (rdy2 !== exp_oh) begin miscompares++; $display("[TB] FAIL contention_grant%0d got %b expected %b", k, rdy2, exp_oh); end
            @(posedge clk); #1;
            @(negedge clk);
            vectors++; if (rdy2 !== 2'b00) begin miscompares++; $display("[TB] FAIL contention_exec_ready%0d got %b expected 00", k, rdy2); end
            @(posedge clk); #1;
            @(negedge clk);
            vectors++; if (rv2 !== exp_oh) begin miscompares++; $display("[TB] FAIL contention_rsp_valid%0d got %b expected %b", k, rv2, exp_oh); end
            vectors++; if (rd2 !== exp_res) begin miscompares++; $display("[TB] FAIL contention_rsp_data%0d got %h expected %h", k, rd2, exp_res); end
            @(posedge clk); #1;
        end
        v2 = 2'b00;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req2(1, ALU_OP_ADD, 100, 23);
        set_req2(0, ALU_OP_XOR, 32'h0000_FF00, 32'h0000_0FF0);
        v2 = 2'b10; rr2 = 2'b00;
        @(negedge clk);
        vectors++; if (rdy2 !== 2'b10) begin miscompares++; $display("[TB] FAIL bp_grant got %b expected 10", rdy2); end
        @(posedge clk); #1; v2 = 2'b01;
        @(negedge clk);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++; if ({rv2, rdy2, busy2} !== 5'b10001) begin miscompares++; $display("[TB] FAIL bp_hold%0d got rv=%b rdy=%b busy=%b expected 10/00/1", k, rv2, rdy2, busy2); end
            vectors++; if (rd2 !== DW'(123)) begin miscompares++; $display("[TB] FAIL bp_data%0d got %0d expected 123", k, rd2); end
            @(posedge clk); #1;
        end
        rr2 = 2'b10;
        @(negedge clk);
        vectors++; if ({rv2, rdy2} !== 4'b1000) begin miscompares++; $display("[TB] FAIL bp_release_cycle got rv=%b rdy=%b expected 10/00", rv2, rdy2); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if ({busy2, rv2, rdy2} !== 5'b00001) begin miscompares++; $display("[TB] FAIL bp_idle got busy=%b rv=%b rdy=%b expected 0/00/01", busy2, rv2, rdy2); end
        rr2 = 2'b11;
        @(posedge clk); #1; v2 = 2'b00;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (rd2 !== DW'(32'h0000_F0F0) || rv2 !== 2'b01) begin miscompares++; $display("[TB] FAIL bp_followup got rv=%b data=%h expected 01/0000f0f0", rv2, rd2); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrong_owner();
        do_reset();
        set_req2(0, ALU_OP_OR, 32'hF0, 32'h0F);
        v2 = 2'b01; rr2 = 2'b10;
        @(negedge clk);
        @(posedge clk); #1; v2 = 2'b00;
        @(negedge clk);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++; if ({rv2, busy2} !== 3'b011 || rd2 !== DW'(32'hFF)) begin miscompares++; $display("[TB] FAIL wrong_owner%0d got rv=%b busy=%b data=%h expected 01/1/ff", k, rv2, busy2, rd2); end
            @(posedge clk); #1;
        end
        rr2 = 2'b01;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("[TB] FAIL wrong_owner_release got busy=%b expected 0", busy2); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        set_req2(1, ALU_OP_SRA, 32'h8000_0000, 4);
        v2 = 2'b10; rr2 = 2'b11;
        @(negedge clk);
        vectors++; if (rdy2 !== 2'b10) begin miscompares++; $display("[TB] FAIL midreset_grant got %b expected 10", rdy2); end
        @(posedge clk); #1; v2 = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({rv2, rdy2, busy2} !== 5'b0 || {rd2, aa2, ab2, aop2} !== '0) begin miscompares++; $display("[TB] FAIL midreset_zero got rv=%b rdy=%b busy=%b data=%h a=%h b=%h op=%h expected all 0", rv2, rdy2, busy2, rd2, aa2, ab2, aop2); end
        set_req2(0, ALU_OP_ADD, 1, 2);
        v2 = 2'b11;
        #1;
        vectors++; if (rdy2 !== 2'b00) begin miscompares++; $display("[TB] FAIL midreset_ready_in_reset got %b expected 00", rdy2); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        vectors++; if ({rdy2, rv2} !== 4'b0100) begin miscompares++; $display("[TB] FAIL midreset_first_grant got rdy=%b rv=%b expected 01/00", rdy2, rv2); end
        @(posedge clk); #1; v2 = 2'b10;
        @(negedge clk);
        vectors++; if ({rv2, busy2} !== 3'b001) begin miscompares++; $display("[TB] FAIL midreset_no_stale got rv=%b busy=%b expected 00/1", rv2, busy2); end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (rv2 !== 2'b01 || rd2 !== DW'(3)) begin miscompares++; $display("[TB] FAIL midreset_result got rv=%b data=%h expected 01/3", rv2, rd2); end
        @(posedge clk); #1; v2 = 2'b00;
    endtask

    task automatic test_wrap();
        logic [3:0] exp_oh;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a4[i*DW +: DW] = DW'(i * 10);
            b4[i*DW +: DW] = DW'(i);
            op4[i*OPW +: OPW] = ALU_OP_ADD;
        end
        v4 = 4'b1111; rr4 = 4'b1111;
        #1;
        vectors++; if (rdy4 !== 4'b0001) begin miscompares++; $display("[TB] FAIL wrap_all_valid got %b expected 0001", rdy4); end
        v4 = 4'b0100;
        #1;
        vectors++; if (rdy4 !== 4'b0100) begin miscompares++; $display("[TB] FAIL wrap_only_req2 got %b expected 0100", rdy4); end
        v4 = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'(1 << (k % 4));
            @(negedge clk);
            vectors++; if (rdy4 !== exp_oh) begin miscompares++; $display("[TB] FAIL wrap_grant%0d got %b expected %b", k, rdy4, exp_oh); end
            @(posedge clk); #1;
            @(negedge clk);
            @(posedge clk); #1;
            @(negedge clk);
            vectors++; if (rv4 !== exp_oh || rd4 !== DW'((k % 4) * 11)) begin miscompares++; $display("[TB] FAIL wrap_rsp%0d got rv=%b data=%0d expected %b/%0d", k, rv4, rd4, exp_oh, (k % 4) * 11); end
            @(posedge clk); #1;
        end
        v4 = 4'b0000;
    endtask

    task automatic test_random();
        int last, owner, age, winner, c;
        bit inflight;
        bit pv[2];
        logic [DW-1:0] pa[2], pb[2], exp_a, exp_b, exp_res;
        logic [OPW-1:0] pop[2], exp_op;
        logic [1:0] exp_rdy, exp_rv;
        do_reset();
        last = 1; inflight = 0; owner = 0; age = 0;
        for (int i = 0; i < 2; i++) begin pv[i] = 0; pa[i] = '0; pb[i] = '0; pop[i] = '0; end
        exp_a = '0; exp_b = '0; exp_op = '0; exp_res = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i]  = 1;
                    pa[i]  = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 40)) : DW'($urandom);
                    pb[i]  = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 40)) : DW'($urandom);
                    pop[i] = OPW'($urandom_range(0, 8));
                end else if (pv[i] && $urandom_range(0, 15) == 0) begin
                    pv[i] = 0;
                end
                v2[i] = pv[i];
                set_req2(i, pop[i], pa[i], pb[i]);
            end
            rr2 = 2'($urandom_range(0, 3));
            @(negedge clk);
            winner = -1;
            if (!inflight) begin
                for (int j = 1; j <= 2; j++) begin
                    c = (last + j) % 2;
                    if (pv[c] && winner < 0) winner = c;
                end
                exp_rdy = (winner >= 0) ? 2'(1 << winner) : 2'b00;
                vectors++; if ({rdy2, rv2, busy2} !== {exp_rdy, 3'b000}) begin miscompares++; $display("[TB] FAIL rand_idle cyc%0d got rdy=%b rv=%b busy=%b expected %b/00/0", cyc, rdy2, rv2, busy2, exp_rdy); end
            end else if (age == 1) begin
                vectors++; if ({rdy2, rv2, busy2} !== 5'b00001 || {aa2, ab2, aop2} !== {exp_a, exp_b, exp_op}) begin miscompares++; $display("[TB] FAIL rand_exec cyc%0d got rdy=%b rv=%b busy=%b a=%h b=%h op=%h expected a=%h b=%h op=%h", cyc, rdy2, rv2, busy2, aa2, ab2, aop2, exp_a, exp_b, exp_op); end
            end else begin
                exp_rv = 2'(1 << owner);
                vectors++; if ({rdy2, rv2, busy2} !== {2'b00, exp_rv, 1'b1} || rd2 !== exp_res) begin miscompares++; $display("[TB] FAIL rand_resp cyc%0d got rdy=%b rv=%b busy=%b data=%h expected 00/%b/1 data=%h", cyc, rdy2, rv2, busy2, rd2, exp_rv, exp_res); end
            end
            if (!inflight && winner >= 0) begin
                inflight = 1; age = 1; owner = winner; last = winner;
                exp_a = pa[winner]; exp_b = pb[winner]; exp_op = pop[winner];
                exp_res = alu_model(exp_op, exp_a, exp_b);
                pv[winner] = 0;
            end else if (inflight && age == 1) begin
                age = 2;
            end else if (inflight && rr2[owner]) begin
                inflight = 0;
            end
            @(posedge clk); #1;
        end
        v2 = 2'b00;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_wrong_owner();
        test_reset_mid_op();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t, expected bench to finish earlier", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one ALU (legal range 2..8).
REQ-002 SHALL have parameter ID_W, default $clog2(NUM_REQ), requester index width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester operation request.
REQ-007 req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 req_a, req_b  in  NUM_REQ*`DATA_WIDTH  packed operands; slice i belongs to requester i.
REQ-009 req_op  in  NUM_REQ*`ALU_OP_WIDTH  packed ALU opcodes.
REQ-010 rsp_valid  out  NUM_REQ  result valid; one-hot or zero, targets the owning requester.
REQ-011 rsp_ready  in  NUM_REQ  per-requester result accept.
REQ-012 rsp_data  out  `DATA_WIDTH  result, shared by all requesters.
REQ-013 alu_a, alu_b  out  `DATA_WIDTH  operands to the external shared ALU.
REQ-014 alu_op  out  `ALU_OP_WIDTH  opcode to the external shared ALU.
REQ-015 alu_out  in  `DATA_WIDTH  combinational result from the shared ALU.
REQ-016 busy  out  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have three states, IDLE, EXEC and RESP, with transitions IDLE->EXEC on a request handshake, EXEC->RESP unconditionally, and RESP->IDLE on rsp_valid[id]&rsp_ready[id].
REQ-018 In IDLE, req_ready SHALL be high only for the round-robin winner among the asserted req_valid bits; req_ready SHALL be all-zero in EXEC and RESP.
REQ-019 Round-robin SHALL work as follows: the search starts at last_grant+1 modulo NUM_REQ; last_grant updates only on a handshake.
REQ-020 On a handshake, the block SHALL latch the winner's a, b and op into the operand registers, and latch its index into id.
REQ-021 alu_a, alu_b and alu_op SHALL be driven directly from the operand registers at all times.
REQ-022 In EXEC, the block SHALL register alu_out into rsp_data.
REQ-023 In RESP, rsp_valid[id] SHALL be 1 and all other rsp_valid bits SHALL be 0, with rsp_data held stable until the response handshake.
REQ-024 Latency SHALL be as follows: request handshake at edge t, rsp_valid high from cycle t+2; minimum 3 cycles per operation.
REQ-025 Requesters SHALL hold req_valid and the payload stable until req_ready; req_ready may depend combinationally on req_valid.
REQ-026 A requester dropping req_valid while not granted SHALL be legal and SHALL cause no grant to it.
REQ-027 rsp_ready asserted for a non-owner SHALL be ignored.
REQ-028 In RESP, new requests SHALL NOT be accepted in the same cycle as the response handshake; arbitration resumes in the following IDLE cycle.
REQ-029 The block SHALL not interpret opcodes; all width and arithmetic rules belong to the ALU.

Reset
REQ-030 Asserting rst_n low SHALL immediately force: state=IDLE; req_ready, rsp_valid and busy=0; rsp_data, alu_a, alu_b and alu_op=0; id=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-031 Reset asserted during EXEC or RESP SHALL discard the in-flight operation; no rsp_valid SHALL appear after reset release for that operation.

Structure
REQ-032 Package alu_arbiter_pkg SHALL hold the state enum (IDLE/EXEC/RESP) and the default NUM_REQ.
REQ-033 Widths SHALL come from the existing `DATA_WIDTH/`ALU_OP_WIDTH defines; the ALU_OP_* encodings SHALL be used only by benches.
REQ-034 Sub-module rr_arbiter SHALL be used, with ports NUM_REQ request bits, last_grant and enable in, and a one-hot grant out; it is combinational, and the pointer register lives in alu_arbiter.

Verification
REQ-035 Single request: after reset, req 0 ADD a=5, b=7 -> req_ready[0] same cycle, rsp_valid[0] 2 cycles later, rsp_data=12.
REQ-036 Contention: reqs 0 and 1 both valid continuously with SUB 10-3 and SLT -1<1 -> grants alternate 0,1,0; results 7 and 1 delivered to the matching rsp_valid bit.
REQ-037 Backpressure: rsp_ready[1]=0 for 5 cycles in RESP -> rsp_valid[1] and rsp_data held, req_ready all-zero, busy=1; release -> IDLE next edge.
REQ-038 Wrong-owner ready: in RESP for id=0, rsp_ready=2'b10 -> no transition, rsp_valid[0] stays 1.
REQ-039 Reset mid-op: rst_n low during EXEC of SRA 0x80000000>>4 -> outputs zero immediately; no stale rsp_valid after release; first grant goes to req 0.
REQ-040 Wrap-around (NUM_REQ=4): last_grant=3 with all valid -> next grant 0; with only req 2 valid -> grant 2.
